glove_tracker: RTL
==================

// Module: glove_tracker
// PURPOSE
//  Upstream of the catch game top: turns the per-pixel colour-match flags from the camera threshold
//  stage into per-frame glove centroids, plus an open/closed flag for each of the two gloves.
//  It accumulates match counts and coordinate sums over one camera frame, then divides them with a
//  single shared sequential divider. Results are published as the glove x/y and glove-closed inputs of the game.
// PARAMETERS
//  SUM_W       31   width of coordinate-sum accumulators (1024*768*1023 fits)
//  CNT_W       20   width of per-glove pixel counters
//  MIN_AREA    64   count below this -> glove not seen this frame
//  CLOSED_AREA 600  count in [MIN_AREA, CLOSED_AREA) -> glove closed (fist shows less colour)
// PORTS
//  vclock       in   1   27MHz system clock
//  reset        in   1   synchronous, active-high
//  pix_valid    in   1   current hcount/vcount pixel is an active camera pixel
//  hcount       in   11  pixel x
//  vcount       in   10  pixel y
//  match1       in   1   pixel matches glove-1 colour (qualified by pix_valid)
//  match2       in   1   pixel matches glove-2 colour
//  frame_end    in   1   one-cycle pulse after the last active pixel of a frame
//  glove1x      out  11  glove-1 centroid x
//  glove1y      out  10  glove-1 centroid y
//  glove2x      out  11  glove-2 centroid x
//  glove2y      out  10  glove-2 centroid y
//  glove1_seen  out  1   glove 1 seen in the last published frame
//  glove2_seen  out  1   glove 2 seen in the last published frame
//  glove1closed out  1   glove 1 closed
//  glove2closed out  1   glove 2 closed
//  coords_valid out  1   one-cycle pulse when all outputs update
//  busy         out  1   divider sequence in progress
//  drop_cnt     out  8   frames dropped because frame_end arrived while busy; saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; accumulators cleared; FSM in ACCUM.
//  ACCUM: per cycle, if pix_valid&matchN: cntN+=1, sxN+=hcount, syN+=vcount. match1 and match2 on the same pixel both count.
//  frame_end in ACCUM: copy cnt/sx/sy into shadow regs and clear the accumulators in the same cycle.
//    Accumulation of the next frame starts the following cycle. FSM -> DIV_X1 and busy=1.
//  frame_end while busy: shadows kept, accumulators cleared, drop_cnt+=1 (saturating), FSM unaffected.
//  DIV_X1 -> DIV_Y1 -> DIV_X2 -> DIV_Y2: each state starts the divider with (sum, cnt) and waits for done.
//    The quotient is written to a result reg, truncated to 11 bits (x) or 10 bits (y).
//  Any division for a glove whose cnt < MIN_AREA is skipped (0 cycles) and its result is not written.
//  PUBLISH (1 cycle): update gloveNx/y only where seen; else hold the previous coordinates.
//    gloveN_seen = cnt>=MIN_AREA; gloveNclosed = seen & cnt<CLOSED_AREA, else hold the previous closed value.
//    coords_valid=1 this cycle. Next cycle: busy=0, FSM -> ACCUM.
//  Latency: frame_end -> coords_valid <= 4*(SUM_W+2)+2 cycles (134 at default), well inside vertical blank.
//  Divide by zero cannot occur because of the MIN_AREA gate (MIN_AREA>=1 is required).
//  Accumulators saturate at all-ones; they never wrap.
// CONFIGURATION
//  SMOOTH_EN defined: in PUBLISH, a seen glove's coordinate = (old + new + 1) >> 1 (IIR, rounds half up).
//    The first publish after reset loads the new value directly.
//  SMOOTH_EN undefined: the raw quotient is published.
// STRUCTURE
//  catch_pkg: FSM state encodings (ACCUM, DIV_X1, DIV_Y1, DIV_X2, DIV_Y2, PUBLISH), screen width
//    constants (11/10), and default area thresholds shared with catch_game.
//  Sub-module seq_divider: restoring, one quotient bit per cycle.
//    Ports vclock, reset, start, dividend[SUM_W], divisor[CNT_W], quotient[SUM_W], done.
//    done pulses SUM_W+1 cycles after start.
// TESTING
//  1. 10x10 glove-1 square at x 100..109, y 200..209 -> glove1x=104, glove1y=204, seen=1, closed=1 (100<600).
//     Glove 2: cnt=0 -> seen=0, coords stay 0.
//  2. 30x30 glove-2 block at x 500..529, y 300..329 -> glove2x=514, glove2y=314, seen=1, closed=0.
//     Exactly one coords_valid pulse.
//  3. Glove-1 frame (as test 1), then a frame with 50 matching pixels -> seen=0, glove1x/y hold 104/204.
//  4. Second frame_end 20 cycles after the first -> drop_cnt=1, published values come from the first frame.
//     The next frame accumulates from zero.
//  5. reset asserted mid-divide -> all outputs 0 and busy=0 next cycle; no coords_valid;
//     a following frame publishes correctly.
//  6. SMOOTH_EN: publishes of x=100 then x=111 -> second output 106. Also check a same-pixel match1&match2 frame counts both gloves.

Source files
------------

// File: rtl/catch_pkg.sv
// Shared definitions for the glove tracker and the catch game: FSM encodings,
// screen coordinate widths and default area thresholds.
package catch_pkg;

  typedef enum logic [2:0] {
    ACCUM   = 3'd0,
    DIV_X1  = 3'd1,
    DIV_Y1  = 3'd2,
    DIV_X2  = 3'd3,
    DIV_Y2  = 3'd4,
    PUBLISH = 3'd5
  } state_t;

  localparam int SCREEN_X_W      = 11;
  localparam int SCREEN_Y_W      = 10;
  localparam int DEF_SUM_W       = 31;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_MIN_AREA    = 64;
  localparam int DEF_CLOSED_AREA = 600;

  // Next division state after cur, jumping straight past gloves that were not
  // seen so skipped divisions cost no cycles.
  function automatic state_t next_div(input state_t cur, input logic seen1, input logic seen2);
    state_t nxt;
    nxt = ACCUM;
    case (cur)
      ACCUM:   nxt = seen1 ? DIV_X1 : (seen2 ? DIV_X2 : PUBLISH);
      DIV_X1:  nxt = DIV_Y1;
      DIV_Y1:  nxt = seen2 ? DIV_X2 : PUBLISH;
      DIV_X2:  nxt = DIV_Y2;
      DIV_Y2:  nxt = PUBLISH;
      default: nxt = ACCUM;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses
// SUM_W+1 cycles after start with the quotient held until the next start.
module seq_divider #(
  parameter int SUM_W = 31,
  parameter int CNT_W = 20
) (
  input  logic             vclock,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]  quo_reg;
  logic [CNT_W-1:0]  rem_reg;
  logic [CNT_W-1:0]  div_reg;
  logic [STEP_W-1:0] step_reg;
  logic              running_reg;
  logic              done_reg;
  logic [CNT_W:0]    shifted;
  logic [CNT_W:0]    diff;
  logic              ge;

  // Remainder always stays below the divisor, so CNT_W bits plus the shifted-in bit suffice.
  assign shifted = {rem_reg, quo_reg[SUM_W-1]};
  assign diff    = shifted - {1'b0, div_reg};
  assign ge      = (shifted >= {1'b0, div_reg});

  always_ff @(posedge vclock) begin
    if (reset) begin
      quo_reg     <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      step_reg    <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        quo_reg     <= dividend;
        rem_reg     <= '0;
        div_reg     <= divisor;
        step_reg    <= STEP_W'(SUM_W);
        running_reg <= 1'b1;
      end else if (running_reg) begin
        quo_reg  <= {quo_reg[SUM_W-2:0], ge};
        rem_reg  <= ge ? CNT_W'(diff) : CNT_W'(shifted);
        step_reg <= step_reg - STEP_W'(1);
        if (step_reg == STEP_W'(1)) begin
          running_reg <= 1'b0;
          done_reg    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_reg;
  assign done     = done_reg;

endmodule

// File: rtl/glove_tracker.sv
// Per-frame glove centroid and open/closed tracker feeding the catch game.
// Define SMOOTH_EN to publish an IIR-averaged position instead of the raw centroid.
module glove_tracker
  import catch_pkg::*;
#(
  parameter int SUM_W       = DEF_SUM_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_AREA    = DEF_MIN_AREA,
  parameter int CLOSED_AREA = DEF_CLOSED_AREA
) (
  input  logic                  vclock,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic [SCREEN_X_W-1:0] hcount,
  input  logic [SCREEN_Y_W-1:0] vcount,
  input  logic                  match1,
  input  logic                  match2,
  input  logic                  frame_end,
  output logic [SCREEN_X_W-1:0] glove1x,
  output logic [SCREEN_Y_W-1:0] glove1y,
  output logic [SCREEN_X_W-1:0] glove2x,
  output logic [SCREEN_Y_W-1:0] glove2y,
  output logic                  glove1_seen,
  output logic                  glove2_seen,
  output logic                  glove1closed,
  output logic                  glove2closed,
  output logic                  coords_valid,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  state_t           state_reg, state_next;
  logic             run_reg, run_next;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_quot;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic             coords_valid_reg;
  logic [7:0]       drop_cnt_reg;

  logic                  match_vec [2];
  logic                  seen_live [2];
  logic                  seen_sh   [2];
  logic [CNT_W-1:0]      cnt_sh    [2];
  logic [SUM_W-1:0]      sx_sh     [2];
  logic [SUM_W-1:0]      sy_sh     [2];
  logic [SCREEN_X_W-1:0] pos_x     [2];
  logic [SCREEN_Y_W-1:0] pos_y     [2];
  logic                  seen_out  [2];
  logic                  closed_out[2];

  assign match_vec[0] = match1;
  assign match_vec[1] = match2;

  always_ff @(posedge vclock) begin
    if (reset) begin
      state_reg <= ACCUM;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
    end
  end

  // Each division state spends one cycle issuing start, then waits for done.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    div_start  = 1'b0;
    case (state_reg)
      ACCUM: begin
        if (frame_end) state_next = next_div(ACCUM, seen_live[0], seen_live[1]);
      end
      DIV_X1, DIV_Y1, DIV_X2, DIV_Y2: begin
        if (!run_reg) begin
          div_start = 1'b1;
          run_next  = 1'b1;
        end else if (div_done) begin
          run_next   = 1'b0;
          state_next = next_div(state_reg, seen_sh[0], seen_sh[1]);
        end
      end
      PUBLISH: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    div_dividend = '0;
    div_divisor  = cnt_sh[0];
    case (state_reg)
      DIV_X1: div_dividend = sx_sh[0];
      DIV_Y1: div_dividend = sy_sh[0];
      DIV_X2: begin
        div_dividend = sx_sh[1];
        div_divisor  = cnt_sh[1];
      end
      DIV_Y2: begin
        div_dividend = sy_sh[1];
        div_divisor  = cnt_sh[1];
      end
      default: div_dividend = '0;
    endcase
  end

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .vclock   (vclock),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quot),
    .done     (div_done)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_glove
      localparam state_t X_ST = (gi == 0) ? DIV_X1 : DIV_X2;
      localparam state_t Y_ST = (gi == 0) ? DIV_Y1 : DIV_Y2;

      logic [CNT_W-1:0]      cnt_reg, cnt_sh_reg;
      logic [SUM_W-1:0]      sx_reg, sy_reg, sx_sh_reg, sy_sh_reg;
      logic [SUM_W:0]        sx_add, sy_add;
      logic [SCREEN_X_W-1:0] res_x_reg, x_reg, x_new;
      logic [SCREEN_Y_W-1:0] res_y_reg, y_reg, y_new;
      logic                  seen_reg, closed_reg;

      assign sx_add = {1'b0, sx_reg} + (SUM_W+1)'(hcount);
      assign sy_add = {1'b0, sy_reg} + (SUM_W+1)'(vcount);

`ifdef SMOOTH_EN
      logic has_pos_reg;

      always_ff @(posedge vclock) begin
        if (reset)                             has_pos_reg <= 1'b0;
        else if (state_reg == PUBLISH && seen_sh[gi]) has_pos_reg <= 1'b1;
      end

      // Rounds half up; the very first sighting loads the centroid directly.
      assign x_new = has_pos_reg ?
                     SCREEN_X_W'(({1'b0, x_reg} + {1'b0, res_x_reg} + 12'd1) >> 1) : res_x_reg;
      assign y_new = has_pos_reg ?
                     SCREEN_Y_W'(({1'b0, y_reg} + {1'b0, res_y_reg} + 11'd1) >> 1) : res_y_reg;
`else
      assign x_new = res_x_reg;
      assign y_new = res_y_reg;
`endif

      always_ff @(posedge vclock) begin
        if (reset) begin
          cnt_reg    <= '0;
          sx_reg     <= '0;
          sy_reg     <= '0;
          cnt_sh_reg <= '0;
          sx_sh_reg  <= '0;
          sy_sh_reg  <= '0;
          res_x_reg  <= '0;
          res_y_reg  <= '0;
          x_reg      <= '0;
          y_reg      <= '0;
          seen_reg   <= 1'b0;
          closed_reg <= 1'b0;
        end else begin
          // frame_end always restarts accumulation; shadows only load when the FSM is idle.
          if (frame_end) begin
            cnt_reg <= '0;
            sx_reg  <= '0;
            sy_reg  <= '0;
            if (state_reg == ACCUM) begin
              cnt_sh_reg <= cnt_reg;
              sx_sh_reg  <= sx_reg;
              sy_sh_reg  <= sy_reg;
            end
          end else if (pix_valid && match_vec[gi]) begin
            if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
            sx_reg <= sx_add[SUM_W] ? '1 : sx_add[SUM_W-1:0];
            sy_reg <= sy_add[SUM_W] ? '1 : sy_add[SUM_W-1:0];
          end

          if (div_done && state_reg == X_ST) res_x_reg <= SCREEN_X_W'(div_quot);
          if (div_done && state_reg == Y_ST) res_y_reg <= SCREEN_Y_W'(div_quot);

          if (state_reg == PUBLISH) begin
            seen_reg <= seen_sh[gi];
            if (seen_sh[gi]) begin
              x_reg      <= x_new;
              y_reg      <= y_new;
              closed_reg <= (cnt_sh_reg < CNT_W'(CLOSED_AREA));
            end
          end
        end
      end

      assign seen_live[gi]  = (cnt_reg >= CNT_W'(MIN_AREA));
      assign seen_sh[gi]    = (cnt_sh_reg >= CNT_W'(MIN_AREA));
      assign cnt_sh[gi]     = cnt_sh_reg;
      assign sx_sh[gi]      = sx_sh_reg;
      assign sy_sh[gi]      = sy_sh_reg;
      assign pos_x[gi]      = x_reg;
      assign pos_y[gi]      = y_reg;
      assign seen_out[gi]   = seen_reg;
      assign closed_out[gi] = closed_reg;
    end
  endgenerate

  // coords_valid is registered so it coincides with the updated outputs.
  always_ff @(posedge vclock) begin
    if (reset) begin
      coords_valid_reg <= 1'b0;
      drop_cnt_reg     <= '0;
    end else begin
      coords_valid_reg <= (state_reg == PUBLISH);
      if (frame_end && state_reg != ACCUM && drop_cnt_reg != 8'hFF)
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign glove1x      = pos_x[0];
  assign glove1y      = pos_y[0];
  assign glove2x      = pos_x[1];
  assign glove2y      = pos_y[1];
  assign glove1_seen  = seen_out[0];
  assign glove2_seen  = seen_out[1];
  assign glove1closed = closed_out[0];
  assign glove2closed = closed_out[1];
  assign coords_valid = coords_valid_reg;
  assign busy         = (state_reg != ACCUM);
  assign drop_cnt     = drop_cnt_reg;

endmodule
